// File: rtl/simmem_tb_pkg.sv
// Shared types and LFSR step function for the bank traffic checker.
package simmem_tb_pkg;

  typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} tb_state_e;

  typedef enum logic [1:0] {
    REL_ALL_ONES = 2'd0,
    REL_ONE_HOT  = 2'd1,
    REL_LFSR     = 2'd2
  } release_mode_e;

  localparam logic [15:0] LfsrMask = 16'hB400;

  // Galois form: shift right, fold the mask in when a one falls out.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LfsrMask : 16'h0000);
  endfunction

endpackage

// File: rtl/simmem_tb_lfsr.sv
// 16-bit Galois LFSR with a seed parameter and a step enable.
module simmem_tb_lfsr
  import simmem_tb_pkg::*;
#(
  parameter logic [15:0] Seed = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= Seed;
    else if (en) state <= lfsr_next(state);
  end

endmodule

// File: rtl/simmem_bank_traffic_checker.sv
// Traffic generator and per-ID in-order scoreboard for the linked-list bank.
// Macro SIMMEM_TB_OUT_BACKPRESSURE_EN adds pseudo-random back-pressure on out_ready_o.
//
// state | meaning
// IDLE  | one cycle after reset before traffic starts
// SEND  | injecting messages, tagged {seq, id}
// DRAIN | collecting the remaining outputs
// DONE  | verdict frozen until reset
module simmem_bank_traffic_checker
  import simmem_tb_pkg::*;
#(
  parameter int unsigned StructWidth    = 10,
  parameter int unsigned IDWidth        = 2,
  parameter int unsigned NbInputsToSend = 10,
  parameter int unsigned TimeoutCycles  = 1000,
  parameter logic [15:0] LfsrSeed       = 16'hACE1,
  parameter int unsigned ReleaseMode    = 0,
  parameter bit          Interleave     = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  output logic [StructWidth-1:0]  in_data_o,
  output logic                    in_valid_o,
  input  logic                    in_ready_i,
  input  logic [StructWidth-1:0]  out_data_i,
  input  logic                    out_valid_i,
  output logic                    out_ready_o,
  output logic [2**IDWidth-1:0]   release_en_o,
  output logic [15:0]             err_cnt_o,
  output logic                    test_done_o,
  output logic                    test_passed_o
);

  localparam int unsigned NbIds    = 2**IDWidth;
  localparam int unsigned SeqWidth = StructWidth - IDWidth;

  tb_state_e            state;
  logic [15:0]          lfsr;
  logic [IDWidth-1:0]   next_id;
  logic [SeqWidth-1:0]  sent_seq [NbIds];
  logic [SeqWidth-1:0]  recv_seq [NbIds];
  logic [31:0]          outstanding [NbIds];
  logic [31:0]          sent_total, recv_total, cycle_cnt;
  logic [15:0]          err_cnt;
  logic                 timed_out;
  logic [NbIds-1:0]     rot;

  logic                 in_hs, out_hs, out_err, timeout_hit;
  logic [IDWidth-1:0]   out_id;
  logic [SeqWidth-1:0]  out_seq;
  logic [NbIds-1:0]     inc, dec, pending_oh;
  logic                 unused_lfsr_bits;

  simmem_tb_lfsr #(.Seed(LfsrSeed)) u_lfsr (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .en    (1'b1),
    .state (lfsr)
  );

  assign unused_lfsr_bits = ^lfsr;
  assign out_id      = out_data_i[IDWidth-1:0];
  assign out_seq     = out_data_i[StructWidth-1:IDWidth];
  assign in_valid_o  = (state == SEND);
  assign in_data_o   = {sent_seq[next_id], next_id};
  assign in_hs       = in_valid_o & in_ready_i;
  assign out_hs      = out_ready_o & out_valid_i;
  assign out_err     = out_hs && ((outstanding[out_id] == 32'd0) || (out_seq != recv_seq[out_id]));
  assign timeout_hit = (state != DONE) && (cycle_cnt + 32'd1 == TimeoutCycles);

  always_comb begin
    out_ready_o = (state == DRAIN) || (Interleave && (state == SEND));
`ifdef SIMMEM_TB_OUT_BACKPRESSURE_EN
    out_ready_o = out_ready_o & lfsr[15];
`endif
  end

  always_comb begin
    inc        = '0;
    dec        = '0;
    pending_oh = '0;
    for (int i = NbIds - 1; i >= 0; i--) begin
      inc[i] = in_hs && (next_id == IDWidth'(i));
      dec[i] = out_hs && (out_id == IDWidth'(i)) && (outstanding[i] != 32'd0);
      // Lowest-numbered pending ID always gets a release so draining cannot stall.
      if (outstanding[i] != 32'd0) pending_oh = NbIds'(1) << i;
    end
  end

  always_comb begin
    release_en_o = '0;
    if ((state == SEND) || (state == DRAIN)) begin
      case (release_mode_e'(ReleaseMode[1:0]))
        REL_ONE_HOT: release_en_o = rot;
        REL_LFSR:    release_en_o = lfsr[8 +: NbIds] | pending_oh;
        default:     release_en_o = '1;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= IDLE;
      next_id    <= '0;
      sent_total <= '0;
      recv_total <= '0;
      cycle_cnt  <= '0;
      err_cnt    <= '0;
      timed_out  <= 1'b0;
      rot        <= NbIds'(1);
      for (int i = 0; i < NbIds; i++) begin
        sent_seq[i]    <= '0;
        recv_seq[i]    <= '0;
        outstanding[i] <= '0;
      end
    end else begin
      if (state != DONE) cycle_cnt <= cycle_cnt + 32'd1;
      if ((state == SEND) || (state == DRAIN)) rot <= {rot[NbIds-2:0], rot[NbIds-1]};

      if (in_hs) begin
        next_id           <= lfsr[IDWidth-1:0];
        sent_seq[next_id] <= sent_seq[next_id] + SeqWidth'(1);
        sent_total        <= sent_total + 32'd1;
      end
      if (out_hs) begin
        recv_seq[out_id] <= recv_seq[out_id] + SeqWidth'(1);
        recv_total       <= recv_total + 32'd1;
        if (out_err && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
      end
      for (int i = 0; i < NbIds; i++) begin
        if (inc[i] && !dec[i])      outstanding[i] <= outstanding[i] + 32'd1;
        else if (!inc[i] && dec[i]) outstanding[i] <= outstanding[i] - 32'd1;
      end

      case (state)
        IDLE:    state <= (NbInputsToSend == 0) ? DRAIN : SEND;
        SEND:    if (in_hs && (sent_total + 32'd1 == NbInputsToSend)) state <= DRAIN;
        DRAIN:   if (recv_total == NbInputsToSend) state <= DONE;
        default: ;
      endcase
      if (out_err || timeout_hit) state <= DONE;
      if (timeout_hit) timed_out <= 1'b1;
    end
  end

  assign err_cnt_o     = err_cnt;
  assign test_done_o   = (state == DONE);
  assign test_passed_o = test_done_o && (err_cnt == 16'd0) &&
                         (recv_total == NbInputsToSend) && !timed_out;

endmodule

// File: tb/tb_simmem_bank_traffic_checker.sv
// Directed bench: a one-deep-latency FIFO stands in for the bank; a second
// instance with ReleaseMode = 1 exercises the rotating release pattern.
module tb_simmem_bank_traffic_checker;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [9:0] in_data, out_data;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [3:0] release_en;
  logic [15:0] err_cnt;
  logic       done, passed;

  logic [9:0] b_in_data;
  logic       b_in_valid, b_out_ready, b_done, b_passed;
  logic [3:0] b_release_en;
  logic [15:0] b_err_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [9:0]  q[$];
  bit          model_on, swap_id1;
  int          n_in, n_out, id1_pushes;
  logic [15:0] blfsr;
  logic [1:0]  exp_id;
  logic [7:0]  exp_seq [4];

  always #5 clk_i = ~clk_i;

  simmem_bank_traffic_checker u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_data_o(in_data), .in_valid_o(in_valid), .in_ready_i(in_ready),
    .out_data_i(out_data), .out_valid_i(out_valid), .out_ready_o(out_ready),
    .release_en_o(release_en), .err_cnt_o(err_cnt),
    .test_done_o(done), .test_passed_o(passed)
  );

  simmem_bank_traffic_checker #(.ReleaseMode(1)) u_dut_rot (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_data_o(b_in_data), .in_valid_o(b_in_valid), .in_ready_i(1'b1),
    .out_data_i(10'd0), .out_valid_i(1'b0), .out_ready_o(b_out_ready),
    .release_en_o(b_release_en), .err_cnt_o(b_err_cnt),
    .test_done_o(b_done), .test_passed_o(b_passed)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  task automatic model_clear();
    q.delete();
    n_in = 0; n_out = 0; id1_pushes = 0;
    blfsr = 16'hACE1; exp_id = 2'd0;
    for (int i = 0; i < 4; i++) exp_seq[i] = 8'd0;
  endtask

  // One clock: decide handshakes at the falling edge, update the model after the rising edge.
  task automatic step();
    bit hi, ho;
    int idx;
    logic [9:0] d;
    @(negedge clk_i);
    hi = rst_ni && in_valid && in_ready;
    ho = rst_ni && out_valid && out_ready;
    d  = in_data;
    if (hi) check("in_data", {22'd0, in_data}, {22'd0, exp_seq[exp_id], exp_id});
    @(posedge clk_i);
    #1;
    if (!rst_ni) model_clear();
    else begin
      if (ho) begin q.delete(0); n_out++; end
      if (hi) begin
        n_in++;
        exp_seq[exp_id] = exp_seq[exp_id] + 8'd1;
        idx = -1;
        if (swap_id1 && d[1:0] == 2'd1) begin
          id1_pushes++;
          if (id1_pushes == 2)
            for (int i = q.size() - 1; i >= 0; i--) if (q[i][1:0] == 2'd1) idx = i;
        end
        if (idx >= 0) q.insert(idx, d);
        else q.push_back(d);
        exp_id = blfsr[1:0];
      end
      blfsr = lfsr_step(blfsr);
    end
    out_valid = model_on && (q.size() > 0);
    out_data  = (q.size() > 0) ? q[0] : 10'd0;
  endtask

  task automatic do_reset(input bit model_en);
    rst_ni = 1'b0; in_ready = 1'b1; model_on = model_en; swap_id1 = 1'b0;
    repeat (2) step();
    rst_ni = 1'b1;
  endtask

  initial begin
    int cyc;
    int err_at_out;
    bit err_seen, err_done;
    logic [9:0] held;
    logic [3:0] rot_exp;
    rst_ni = 1'b0; in_ready = 1'b1; out_valid = 1'b0; out_data = '0;
    model_clear();

    // Ideal bank: reset state, rotating release on the second instance, full pass.
    do_reset(1'b1);
    check("rst_in_valid", in_valid, 0);
    check("rst_in_data", in_data, 0);
    check("rst_out_ready", out_ready, 0);
    check("rst_release", release_en, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_done", done, 0);
    check("rst_passed", passed, 0);
    check("rst_rot_release", b_release_en, 0);
    cyc = 0;
    while (!done && cyc < 60) begin
      step();
      cyc++;
      if (cyc <= 5) begin
        rot_exp = 4'b0001 << ((cyc - 1) % 4);
        check("rot_release", b_release_en, rot_exp);
      end
      if (cyc == 3) check("send_release_all", release_en, 4'hF);
    end
    check("ideal_done_by_60", done, 1);
    check("ideal_passed", passed, 1);
    check("ideal_err_cnt", err_cnt, 0);
    check("ideal_in_hs", n_in, 10);
    check("ideal_out_hs", n_out, 10);

    // Input stall after the first send, then the first two ID-1 messages leave swapped.
    do_reset(1'b1);
    swap_id1 = 1'b1;
    step();
    step();
    check("stall_pre_sent", u_dut.sent_total, 1);
    in_ready = 1'b0;
    held = in_data;
    repeat (5) begin
      step();
      check("stall_valid", in_valid, 1);
      check("stall_data", in_data, held);
      check("stall_sent", u_dut.sent_total, 1);
    end
    in_ready = 1'b1;
    cyc = 0; err_seen = 0; err_done = 0; err_at_out = 0;
    while (!done && cyc < 100) begin
      step();
      cyc++;
      if (!err_seen && err_cnt != 16'd0) begin
        err_seen = 1; err_done = done; err_at_out = n_out;
        check("swap_err_cnt", err_cnt, 1);
      end
    end
    check("swap_err_seen", err_seen, 1);
    check("swap_err_at_3rd_out", err_at_out, 3);
    check("swap_done_after_err", err_done, 1);
    check("swap_passed", passed, 0);
    check("swap_sent_all", n_in, 10);

    // Bank never answers: timeout after exactly 1000 cycles.
    do_reset(1'b0);
    cyc = 0;
    while (!done && cyc < 1100) begin
      step();
      cyc++;
    end
    check("timeout_cycle", cyc, 1000);
    check("timeout_passed", passed, 0);
    check("timeout_err_cnt", err_cnt, 0);

    // One-cycle reset mid-SEND, then a clean rerun.
    do_reset(1'b1);
    repeat (5) step();
    check("midrst_pre_sending", in_valid, 1);
    rst_ni = 1'b0;
    step();
    check("midrst_in_valid", in_valid, 0);
    check("midrst_in_data", in_data, 0);
    check("midrst_release", release_en, 0);
    check("midrst_done", done, 0);
    check("midrst_lfsr", u_dut.lfsr, 16'hACE1);
    check("midrst_sent_total", u_dut.sent_total, 0);
    rst_ni = 1'b1;
    cyc = 0;
    while (!done && cyc < 60) begin
      step();
      cyc++;
    end
    check("rerun_done", done, 1);
    check("rerun_passed", passed, 1);
    check("rerun_out_hs", n_out, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
